// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
// The master drives level requests; the slave returns registered completion status.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for the multicycle core: latches a
// request, inserts WAIT_CYCLES wait states, then completes with a one-cycle mem_ready.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int         IDXW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [IDXW-1:0] r_idx;
    logic [31:0]     r_wdata;
    logic            r_write;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic            r_ready;
    logic            r_busy;
    logic            r_err_pulse;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_req_err;
    logic            w_fast;
    logic            w_access;
    logic [IDXW-1:0] w_idx;
    logic [31:0]     w_wdata;
    logic            w_write;
    logic            w_err;
    logic            w_unused_addr;

    assign w_req         = bus.mem_read | bus.mem_write;
    assign w_req_err     = (bus.addr[1:0] != 2'b00) || (bus.mem_read && bus.mem_write);
    assign w_unused_addr = ^bus.addr[31:IDXW+2];

    // With zero wait states the access happens on the latching edge itself, so the
    // live inputs feed the array instead of the latched copies.
    assign w_fast   = (WAIT_CYCLES == 0) && (r_state == S_IDLE) && w_req;
    assign w_access = w_fast || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_idx    = w_fast ? bus.addr[IDXW+1:2] : r_idx;
    assign w_wdata  = w_fast ? bus.wdata          : r_wdata;
    assign w_write  = w_fast ? bus.mem_write      : r_write;
    assign w_err    = w_fast ? w_req_err          : r_err;

    // A reset on the completing edge aborts the access, so the write is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_write && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_wdata     <= 32'd0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_ready     <= 1'b0;
            r_err_pulse <= 1'b0;
            if (w_access) begin
                if (w_err) begin
                    r_rdata <= 32'd0;
                end else if (!w_write) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= bus.addr[IDXW+1:2];
                        r_wdata <= bus.wdata;
                        r_write <= bus.mem_write;
                        r_err   <= w_req_err;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= S_DONE;
                            r_ready     <= 1'b1;
                            r_err_pulse <= w_req_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_err_pulse <= r_err;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.mem_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err_pulse;
endmodule
